// File: rtl/qpsk_modulator.sv
// QPSK mapper: one 7-bit word in, four +/-AMP I/Q symbols out over a valid/ready stream.
// The bit layout is the inverse of the receive-side sign slicer, so four symbols round-trip to the word.
module qpsk_modulator #(
  parameter logic signed [15:0] AMP   = 16'sd11585,
  parameter int                 CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [6:0]               data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic signed [15:0]       sym_real,
  output logic signed [15:0]       sym_imag,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic [1:0]               sym_idx,
  output logic                     sym_last,
  output logic [CNT_W-1:0]         frame_count
);

  localparam logic signed [15:0] NAMP = -AMP;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              r_state, w_state_nxt;
  logic [6:0]          r_word, w_word_nxt;
  logic [1:0]          r_idx, w_idx_nxt;
  logic                r_last, w_last_nxt;
  logic signed [15:0]  r_re, w_re_nxt;
  logic signed [15:0]  r_im, w_im_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [31:0]         w_map;
  logic                w_end_hs;

  // Pairs map lo->I sign, hi->Q sign; the last symbol carries bit 0 on Q with I pinned positive.
  function automatic logic [31:0] map_sym(input logic [6:0] w, input logic [1:0] idx);
    logic hi, lo;
    case (idx)
      2'd0:    begin hi = w[6]; lo = w[5]; end
      2'd1:    begin hi = w[4]; lo = w[3]; end
      2'd2:    begin hi = w[2]; lo = w[1]; end
      default: begin hi = w[0]; lo = 1'b0; end
    endcase
    return {(lo ? NAMP : AMP), (hi ? NAMP : AMP)};
  endfunction

  assign w_end_hs   = (r_state == EMIT) && (r_idx == 2'd3) && sym_ready;
  assign data_ready = (r_state == IDLE) || w_end_hs;

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_re_nxt    = r_re;
    w_im_nxt    = r_im;
    w_cnt_nxt   = r_cnt;
    w_map       = '0;
    case (r_state)
      IDLE: begin
        if (data_valid) begin
          w_map       = map_sym(data_in, 2'd0);
          w_state_nxt = EMIT;
          w_word_nxt  = data_in;
          w_idx_nxt   = 2'd0;
          w_last_nxt  = 1'b0;
          w_re_nxt    = w_map[31:16];
          w_im_nxt    = w_map[15:0];
        end
      end
      EMIT: begin
        if (sym_ready) begin
          if (r_idx != 2'd3) begin
            w_map      = map_sym(r_word, r_idx + 2'd1);
            w_idx_nxt  = r_idx + 2'd1;
            w_last_nxt = (r_idx == 2'd2);
            w_re_nxt   = w_map[31:16];
            w_im_nxt   = w_map[15:0];
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (data_valid) begin
              // Next word chained in on the same edge, so there is no bubble.
              w_map      = map_sym(data_in, 2'd0);
              w_word_nxt = data_in;
              w_idx_nxt  = 2'd0;
              w_last_nxt = 1'b0;
              w_re_nxt   = w_map[31:16];
              w_im_nxt   = w_map[15:0];
            end else begin
              w_state_nxt = IDLE;
              w_idx_nxt   = 2'd0;
              w_last_nxt  = 1'b0;
              w_re_nxt    = '0;
              w_im_nxt    = '0;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
      r_last <= 1'b0;
      r_re   <= '0;
      r_im   <= '0;
      r_cnt  <= '0;
    end else begin
      r_word <= w_word_nxt;
      r_idx  <= w_idx_nxt;
      r_last <= w_last_nxt;
      r_re   <= w_re_nxt;
      r_im   <= w_im_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign sym_valid   = (r_state == EMIT);
  assign sym_real    = r_re;
  assign sym_imag    = r_im;
  assign sym_idx     = r_idx;
  assign sym_last    = r_last;
  assign frame_count = r_cnt;

endmodule

// File: tb/tb_qpsk_modulator.sv
// Scoreboard bench for qpsk_modulator: expected symbols queued at accept, popped on each symbol handshake,
// with a sign-slicing demodulator recovering each word for the loopback check.
module tb_qpsk_modulator;

  localparam logic signed [15:0] AMP  = 16'sd11585;
  localparam logic signed [15:0] NAMP = -AMP;

  logic clk, rst_n;
  logic [6:0] data_in;
  logic data_valid, data_ready;
  logic signed [15:0] sym_real, sym_imag;
  logic sym_valid, sym_ready, sym_last;
  logic [1:0] sym_idx;
  logic [15:0] frame_count;

  logic [6:0] w_din;
  logic w_dv, w_dr, w_sv, w_sr, w_sl;
  logic signed [15:0] w_re, w_im;
  logic [1:0] w_idx;
  logic [1:0] w_fc;

  qpsk_modulator #(.AMP(AMP), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .sym_real(sym_real), .sym_imag(sym_imag), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_idx(sym_idx), .sym_last(sym_last), .frame_count(frame_count)
  );

  qpsk_modulator #(.AMP(AMP), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .data_in(w_din), .data_valid(w_dv), .data_ready(w_dr),
    .sym_real(w_re), .sym_imag(w_im), .sym_valid(w_sv), .sym_ready(w_sr),
    .sym_idx(w_idx), .sym_last(w_sl), .frame_count(w_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int exp_frames = 0;
  bit rand_rdy = 0;
  logic [34:0] sb[$];
  logic [6:0]  words[$];
  logic [6:0]  dm_word;

  function automatic void push_word(input logic [6:0] w);
    logic signed [15:0] re, im;
    for (int s = 0; s < 4; s++) begin
      if (s < 3) begin
        re = w[5 - 2*s] ? NAMP : AMP;
        im = w[6 - 2*s] ? NAMP : AMP;
      end else begin
        re = AMP;
        im = w[0] ? NAMP : AMP;
      end
      sb.push_back({re, im, 2'(s), (s == 3)});
    end
    words.push_back(w);
  endfunction

  // Negedge sample point: record accepts, score handshaken symbols, run the demodulator.
  task automatic step_neg();
    logic [34:0] e;
    int i;
    logic [6:0] ew;
    @(negedge clk);
    if (!rst_n) return;
    if (sym_valid && sym_ready) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL sb_underflow: got I=%h Q=%h idx=%0d, required no symbol", sym_real, sym_imag, sym_idx);
      end else begin
        e = sb.pop_front();
        if ({sym_real, sym_imag, sym_idx, sym_last} !== e) begin
          nerr++;
          $display("FAIL symbol: got I=%h Q=%h idx=%0d last=%b, required I=%h Q=%h idx=%0d last=%b",
                   sym_real, sym_imag, sym_idx, sym_last, e[34:19], e[18:3], e[2:1], e[0]);
        end
        i = int'(e[2:1]);
        if (i < 3) begin
          dm_word[6 - 2*i] = sym_imag[15];
          dm_word[5 - 2*i] = sym_real[15];
        end else begin
          dm_word[0] = sym_imag[15];
          exp_frames++;
          ew = words.pop_front();
          nvec++;
          if (dm_word !== ew || sym_real[15]) begin
            nerr++;
            $display("FAIL loopback: recovered %h (I3 sign %b), required %h (I3 sign 0)", dm_word, sym_real[15], ew);
          end
        end
      end
    end
    if (data_valid && data_ready) push_word(data_in);
  endtask

  task automatic step_pos();
    @(posedge clk);
    #1;
    if (rand_rdy) sym_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [6:0] w);
    bit hit = 0;
    data_in = w;
    data_valid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      step_neg();
      if (data_ready) begin hit = 1; break; end
      step_pos();
    end
    if (!hit) begin
      nvec++; nerr++;
      $display("FAIL send_timeout: data_ready stayed 0, required 1 within 500 cycles");
    end
    step_pos();
    data_valid = 1'b0;
    data_in = 7'($urandom);
  endtask

  task automatic drain();
    bit done = 0;
    for (int t = 0; t < 3000; t++) begin
      step_neg();
      if (sb.size() == 0 && !sym_valid) begin done = 1; break; end
      step_pos();
    end
    step_pos();
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: %0d symbols pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      data_in = 7'($urandom); data_valid = 1'($urandom); sym_ready = 1'($urandom);
      @(negedge clk);
      nvec++;
      if (sym_valid !== 1'b0 || sym_real !== 16'sd0 || sym_imag !== 16'sd0 ||
          frame_count !== 16'd0 || data_ready !== 1'b1 || sym_idx !== 2'd0 || sym_last !== 1'b0) begin
        nerr++;
        $display("FAIL reset_hold: got v=%b I=%h Q=%h fc=%0d rdy=%b idx=%0d, required v=0 I=0 Q=0 fc=0 rdy=1 idx=0",
                 sym_valid, sym_real, sym_imag, frame_count, data_ready, sym_idx);
      end
      @(posedge clk); #1;
    end
    data_valid = 1'b0; sym_ready = 1'b1;
    rst_n = 1'b1;
    // Abandon a word mid-flight with an asynchronous reset.
    send(7'h55);
    step_neg();
    step_pos();
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (sym_valid !== 1'b0 || sym_real !== 16'sd0 || sym_imag !== 16'sd0 || sym_idx !== 2'd0 || frame_count !== 16'd0) begin
      nerr++;
      $display("FAIL reset_async: got v=%b I=%h Q=%h idx=%0d fc=%0d, required all 0",
               sym_valid, sym_real, sym_imag, sym_idx, frame_count);
    end
    sb.delete(); words.delete(); exp_frames = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step_neg();
      nvec++;
      if (sym_valid !== 1'b0) begin
        nerr++;
        $display("FAIL reset_no_resume: cycle %0d sym_valid=%b, required 0", c, sym_valid);
      end
      step_pos();
    end
  endtask

  task automatic test_single_word();
    logic [15:0] ei[4] = '{16'h2D41, 16'hD2BF, 16'h2D41, 16'h2D41};
    logic [15:0] eq[4] = '{16'hD2BF, 16'hD2BF, 16'h2D41, 16'hD2BF};
    sym_ready = 1'b1;
    send(7'b1011001);
    for (int s = 0; s < 4; s++) begin
      step_neg();
      nvec++;
      if (sym_valid !== 1'b1 || sym_real !== ei[s] || sym_imag !== eq[s] || sym_idx !== 2'(s) || sym_last !== (s == 3)) begin
        nerr++;
        $display("FAIL single_sym%0d: got v=%b I=%h Q=%h idx=%0d last=%b, required v=1 I=%h Q=%h idx=%0d last=%b",
                 s, sym_valid, sym_real, sym_imag, sym_idx, sym_last, ei[s], eq[s], s, (s == 3));
      end
      step_pos();
    end
    step_neg();
    nvec++;
    if (sym_valid !== 1'b0 || frame_count !== 16'd1 || sym_real !== 16'sd0 || sym_imag !== 16'sd0) begin
      nerr++;
      $display("FAIL single_end: got v=%b fc=%0d I=%h Q=%h, required v=0 fc=1 I=0 Q=0",
               sym_valid, frame_count, sym_real, sym_imag);
    end
    step_pos();
  endtask

  task automatic test_back_to_back();
    sym_ready = 1'b1;
    data_in = 7'h00; data_valid = 1'b1;
    step_neg();
    step_pos();
    data_in = 7'h7F;
    for (int k = 0; k < 8; k++) begin
      step_neg();
      nvec++;
      if (sym_valid !== 1'b1 || data_ready !== ((k % 4) == 3)) begin
        nerr++;
        $display("FAIL b2b_cycle%0d: got v=%b rdy=%b, required v=1 rdy=%b", k, sym_valid, data_ready, ((k % 4) == 3));
      end
      step_pos();
      if (k == 3) data_valid = 1'b0;
    end
    step_neg();
    nvec++;
    if (sym_valid !== 1'b0 || frame_count !== 16'(exp_frames)) begin
      nerr++;
      $display("FAIL b2b_end: got v=%b fc=%0d, required v=0 fc=%0d", sym_valid, frame_count, exp_frames);
    end
    step_pos();
  endtask

  task automatic test_backpressure();
    sym_ready = 1'b1;
    send(7'b0110100);
    step_neg();
    step_pos();
    sym_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step_neg();
      nvec++;
      if (sym_valid !== 1'b1 || sym_idx !== 2'd1 || sym_real !== AMP || sym_imag !== NAMP ||
          data_ready !== 1'b0 || sym_last !== 1'b0) begin
        nerr++;
        $display("FAIL stall%0d: got v=%b idx=%0d I=%h Q=%h rdy=%b, required v=1 idx=1 I=%h Q=%h rdy=0",
                 c, sym_valid, sym_idx, sym_real, sym_imag, data_ready, AMP, NAMP);
      end
      step_pos();
    end
    sym_ready = 1'b1;
    drain();
  endtask

  task automatic test_loopback();
    rand_rdy = 1;
    for (int w = 0; w < 128; w++) send(7'(w));
    drain();
    rand_rdy = 0;
    sym_ready = 1'b1;
    nvec++;
    if (words.size() != 0 || frame_count !== 16'(exp_frames)) begin
      nerr++;
      $display("FAIL loopback_end: %0d words unrecovered, fc=%0d, required 0 and fc=%0d",
               words.size(), frame_count, exp_frames);
    end
  endtask

  task automatic test_wrap();
    int acc = 0;
    w_sr = 1'b1; w_dv = 1'b1; w_din = 7'($urandom);
    for (int t = 0; t < 200 && acc < 5; t++) begin
      @(negedge clk);
      if (w_dv && w_dr) acc++;
      @(posedge clk); #1;
      w_din = 7'($urandom);
      if (acc == 5) w_dv = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1;
    nvec++;
    if (acc != 5 || w_fc !== 2'd1 || w_sv !== 1'b0) begin
      nerr++;
      $display("FAIL wrap: accepted %0d fc=%0d v=%b, required 5 words fc=1 v=0", acc, w_fc, w_sv);
    end
  endtask

  initial begin
    data_in = '0; data_valid = 1'b0; sym_ready = 1'b1; rst_n = 1'b0;
    w_din = '0; w_dv = 1'b0; w_sr = 1'b1;
    dm_word = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_loopback();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/qpsk_modulator.md
Name: qpsk_modulator

Overview:
Transmit-side QPSK mapper. Accepts one 7-bit data word per handshake and emits it as four sequential 16-bit signed I/Q symbols over a valid/ready stream, for the pulse-shaping/DAC path. The bit-to-quadrant mapping is the exact inverse of the receive-side sign-slicing demodulator, so the demodulator recovers the original word from four symbols. The final symbol carries one data bit on Q, with I fixed positive.

Parameters:
AMP, 16'sd11585, positive symbol magnitude (0.7071 in Q1.14); each output is +AMP or -AMP.
CNT_W, 16, width of the wrapping frame counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  7  word to modulate; bits [6:5], [4:3] and [2:1] are symbol pairs 0..2; bit [0] is symbol 3
data_valid  input  1  data_in is valid
data_ready  output  1  block can accept a word this cycle (combinational)
sym_real  output  16  signed I component, registered
sym_imag  output  16  signed Q component, registered
sym_valid  output  1  sym_real/sym_imag are valid, registered
sym_ready  input  1  downstream accepts the current symbol
sym_idx  output  2  index 0..3 of the current symbol within its word
sym_last  output  1  high with symbol 3
frame_count  output  CNT_W  number of completed words, wraps at 2^CNT_W

Behaviour:
- Reset (async, rst_n=0): all registered outputs return to 0, the FSM goes to IDLE, and the latched word is cleared. A reset mid-word abandons the word without finishing it.
- FSM states:
  - IDLE: sym_valid=0, sym_real=sym_imag=0.
  - EMIT: sym_valid=1.
- data_ready = (state==IDLE) OR (state==EMIT AND sym_idx==3 AND sym_ready).
- Accept: data_valid AND data_ready latches data_in. On the next edge the block enters EMIT with sym_idx=0 and symbol 0 on the outputs. Latency from accept to sym_valid is 1 cycle.
- Pair mapping for pair {hi,lo}:
  - sym_real = lo ? -AMP : +AMP.
  - sym_imag = hi ? -AMP : +AMP.
  - Resulting codes: 00->(+,+), 01->(-,+), 10->(+,-), 11->(-,-).
- Symbol order and source bits:
  - Symbol 0 uses bits [6:5].
  - Symbol 1 uses bits [4:3].
  - Symbol 2 uses bits [2:1].
  - Symbol 3: sym_real=+AMP; sym_imag = bit0 ? -AMP : +AMP.
- Stall: while sym_valid=1 and sym_ready=0, sym_real, sym_imag, sym_idx and sym_last hold stable.
- Advance: on sym_valid AND sym_ready with sym_idx<3, sym_idx increments and the next symbol is driven on the following edge.
- End of word: on the sym_idx==3 handshake, frame_count increments (wraps from 2^CNT_W-1 to 0).
  - If a new word is accepted in the same cycle, the block stays in EMIT and the next cycle shows symbol 0 of the new word, with no bubble.
  - Otherwise the block goes to IDLE and clears sym_valid and the symbol outputs.
- Throughput: with sym_ready held at 1 and data_valid held at 1, one word every 4 cycles and sym_valid continuously high.
- data_in is ignored unless accepted; changes to data_in after accept do not affect the word in flight.
- -AMP is the two's complement of AMP. AMP must be in 1..32767.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> sym_valid=0, outputs 0, frame_count=0, data_ready=1. Assert rst_n=0 asynchronously mid-word -> outputs clear immediately, no partial continuation after release.
- Single word, AMP=0x2D41, data_in=7'b1011001, sym_ready=1 -> symbol sequence (I,Q):
  - sym 0: (0x2D41, 0xD2BF)
  - sym 1: (0xD2BF, 0xD2BF)
  - sym 2: (0x2D41, 0x2D41)
  - sym 3: (0x2D41, 0xD2BF), sym_last=1
  - then sym_valid=0 and frame_count=1.
- Back-to-back words 7'h00 then 7'h7F, data_valid held high -> 8 consecutive valid cycles:
  - four symbols of (+AMP,+AMP), the last with Q=+AMP;
  - then three symbols of (-AMP,-AMP) and a final (+AMP,-AMP);
  - no gap between words, data_ready high only on the idx-3 cycles.
- Backpressure: drop sym_ready for 3 cycles at sym_idx=1 -> outputs and sym_idx frozen during the stall, data_ready=0, then the sequence resumes.
- Loopback: drive all 128 words through the receive-side demodulator with random sym_ready -> recovered word equals input for every value.
- Counter wrap with CNT_W=2: send 5 words -> frame_count reads 1 at the end.
